// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the switch/button debouncer.
//   state_t               - FSM state encoding (2 bits)
//   STABLE_CYCLES_DEFAULT - default qualification length in clk cycles
package debounce_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; clears both flops
//   d     - asynchronous input level
//   q     - synchronized level (second flop)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/debounce.sv
// debounce
// Debounces a raw switch/button level. A new level is accepted only after it
// has been sampled on STABLE_CYCLES consecutive rising edges; any sample of
// the old level during qualification abandons the attempt and pulses glitch_o.
// Optional build macro DEBOUNCE_SYNC_EN inserts a two-flop synchronizer
// (sync_2ff) in front of the FSM, adding two cycles of latency.
// Parameters:
//   STABLE_CYCLES - consecutive samples needed to accept a change (2..65535)
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high
//   a_i      - raw input level
//   a_o      - debounced, registered level
//   busy_o   - high while a candidate change is being qualified
//   glitch_o - one-cycle pulse when a candidate change is abandoned
module debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic a_i,
  output logic a_o,
  output logic busy_o,
  output logic glitch_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_d;
  logic          glitch_d;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (a_i),
    .q     (s)
  );
`else
  assign s = a_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      a_o      <= 1'b0;
      glitch_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_o      <= a_d;
      glitch_o <= glitch_d;
    end
  end

  // The entering sample already counts as the first one, so a WAIT state is
  // entered with cnt=1 and accepts when the STABLE_CYCLES-th sample arrives.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_o;
    glitch_d = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          a_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          a_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_debounce.sv
// tb_debounce
// Self-checking bench for debounce with STABLE_CYCLES=4. Build with or without
// DEBOUNCE_SYNC_EN; expected timing shifts by two edges when it is defined.
module tb_debounce;

  localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int ACC = LAT + N - 1;

  logic clk = 1'b0;
  logic reset;
  logic a_i;
  logic a_o;
  logic busy_o;
  logic glitch_o;

  int assertions = 0;
  int failures   = 0;

  // Reference model: run of consecutive samples differing from the accepted
  // level; a run reaching N flips the level, a run broken early is a glitch.
  bit m_ao, m_busy, m_glitch;
  int m_run;
  bit pipe0, pipe1;

  debounce #(.STABLE_CYCLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_i      (a_i),
    .a_o      (a_o),
    .busy_o   (busy_o),
    .glitch_o (glitch_o)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    m_ao = 0; m_busy = 0; m_glitch = 0; m_run = 0;
    pipe0 = 0; pipe1 = 0;
  endfunction

  function automatic void modelEdge(input bit a);
    bit s;
    s = (LAT != 0) ? pipe1 : a;
    pipe1 = pipe0;
    pipe0 = a;
    m_glitch = 0;
    if (s != m_ao) begin
      m_run++;
      if (m_run == N) begin
        m_ao  = !m_ao;
        m_run = 0;
      end
    end else begin
      if (m_run > 0) m_glitch = 1;
      m_run = 0;
    end
    m_busy = (m_run > 0);
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, ".a_o"},      a_o,      m_ao);
    checkBit({tag, ".busy_o"},   busy_o,   m_busy);
    checkBit({tag, ".glitch_o"}, glitch_o, m_glitch);
  endtask

  // Drive one sample, let one rising edge consume it, then compare.
  task automatic applyStimulus(input bit a, input string tag);
    a_i = a;
    @(posedge clk);
    #1;
    modelEdge(a);
    checkOutput(tag);
  endtask

  task automatic doReset();
    reset = 1'b1;
    a_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("reset_held");
    reset = 1'b0;
  endtask

  // Assert reset away from any clock edge and expect outputs to clear at once.
  task automatic asyncReset(input string tag);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput({tag, ".async"});
    @(posedge clk);
    #1;
    checkOutput({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    int gl_count;
    bit lvl;
    int len;
    bit pat [6];
    reset = 1'b1;
    a_i   = 1'b0;
    modelReset();
    $display("[TB] Start, STABLE_CYCLES=%0d sync latency=%0d", N, LAT);

    // Reset then a_i held high: busy from edge LAT, accept at edge ACC.
    doReset();
    for (int i = 0; i <= ACC + 1; i++) begin
      applyStimulus(1'b1, "hold_hi");
      checkBit("hold_hi.a_o_const",  a_o,    (i >= ACC));
      checkBit("hold_hi.busy_const", busy_o, (i >= LAT) && (i < ACC));
    end

    // Two-cycle high pulse then low: abandoned, single glitch, a_o stays 0.
    doReset();
    gl_count = 0;
    for (int i = 0; i < 2 + LAT + 4; i++) begin
      applyStimulus((i < 2), "short_pulse");
      gl_count += int'(glitch_o);
      checkBit("short_pulse.a_o_const", a_o, 1'b0);
    end
    checkBit("short_pulse.one_glitch", (gl_count == 1), 1'b1);

    // Accepted high, then bounce 0,1,0,0,0,0: one glitch, fall at edge LAT+5.
    doReset();
    for (int i = 0; i <= ACC; i++) applyStimulus(1'b1, "pre_hi");
    pat = '{0, 1, 0, 0, 0, 0};
    gl_count = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      applyStimulus((i < 6) ? pat[i] : 1'b0, "bounce_lo");
      gl_count += int'(glitch_o);
      checkBit("bounce_lo.a_o_const", a_o, (i < LAT + 5));
    end
    checkBit("bounce_lo.one_glitch", (gl_count == 1), 1'b1);

    // Reset during WAIT_HI with cnt=2, then full latency again.
    doReset();
    for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b1, "pre_wait");
    checkBit("pre_wait.busy_const", busy_o, 1'b1);
    asyncReset("mid_wait");
    checkBit("mid_wait.glitch_const", glitch_o, 1'b0);
    for (int i = 0; i <= ACC; i++) begin
      applyStimulus(1'b1, "post_reset");
      checkBit("post_reset.a_o_const", a_o, (i >= ACC));
    end

    // Random bouncing runs with occasional asynchronous resets.
    lvl = 1'b0;
    for (int r = 0; r < 120; r++) begin
      len = $urandom_range(1, 7);
      lvl = !lvl;
      for (int k = 0; k < len; k++) applyStimulus(lvl, "random");
      if ($urandom_range(0, 29) == 0) asyncReset("random_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
